// File: rtl/vga_timer_param.sv
// vga_timer_param: parametrised VESA-style raster timing generator.
//
// Produces horizontal/vertical position counters for any mode described by
// the visible/porch/sync parameters, plus the decoded sync, blanking and
// start-of-line/start-of-frame strobes that the pixel and sprite renderers
// consume. An internal prescaler divides clk_i down to the pixel rate, and
// enable_i freezes all timing state without losing position.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous reset, active-high; beats enable_i
//   enable_i       1 = timing advances, 0 = all state holds
//   pix_stb_o      one clk_i cycle per pixel, marks the cycle the counters move
//   hsync_o        horizontal sync, H_SYNC_POL level when asserted
//   vsync_o        vertical sync, V_SYNC_POL level when asserted
//   visible_o      current position lies in the active area
//   line_start_o   pixel strobe at x == 0
//   frame_start_o  pixel strobe at x == 0, y == 0
//   position_x_o   horizontal counter
//   position_y_o   vertical counter
//   frame_count_o  completed-frame count, wraps modulo 2^FRAME_W

module vga_timer_param #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned H_SYNC_POL = 0,
  parameter int unsigned V_SYNC_POL = 0,
  parameter int unsigned PIX_DIV    = 1,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned FRAME_W    = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  output logic               pix_stb_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               visible_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic [CNT_W-1:0]   position_x_o,
  output logic [CNT_W-1:0]   position_y_o,
  output logic [FRAME_W-1:0] frame_count_o
);

  // ---------------------------------------------------------------------------
  // Derived timing constants
  // ---------------------------------------------------------------------------
  localparam int unsigned HTotal      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HSyncStart  = H_VISIBLE + H_FRONT;
  localparam int unsigned HSyncEnd    = HSyncStart + H_SYNC;
  localparam int unsigned VSyncStart  = V_VISIBLE + V_FRONT;
  localparam int unsigned VSyncEnd    = VSyncStart + V_SYNC;
  localparam longint unsigned CntSpan = 64'd1 << CNT_W;

  // A one-bit prescaler is kept even at PIX_DIV = 1; it simply never leaves 0.
  localparam int unsigned PreW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [PreW-1:0]  PreMax      = PreW'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] XMax        = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] YMax        = CNT_W'(VTotal - 1);
  localparam logic [CNT_W-1:0] XVisEnd     = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] YVisEnd     = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] XSyncStartC = CNT_W'(HSyncStart);
  localparam logic [CNT_W-1:0] XSyncEndC   = CNT_W'(HSyncEnd);
  localparam logic [CNT_W-1:0] YSyncStartC = CNT_W'(VSyncStart);
  localparam logic [CNT_W-1:0] YSyncEndC   = CNT_W'(VSyncEnd);

  localparam logic HPol = (H_SYNC_POL != 0);
  localparam logic VPol = (V_SYNC_POL != 0);

  // ---------------------------------------------------------------------------
  // Elaboration-time legality check
  // ---------------------------------------------------------------------------
  if (PIX_DIV < 1 ||
      H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      CntSpan < 64'(HTotal) || CntSpan < 64'(VTotal)) begin : gen_illegal_params
    $error("vga_timer_param: illegal parameter set (PIX_DIV, porch/sync widths or CNT_W)");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PreW-1:0]    pre_q,   pre_d;
  logic [CNT_W-1:0]   x_q,     x_d;
  logic [CNT_W-1:0]   y_q,     y_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  logic pix_stb;
  logic x_at_end;
  logic y_at_end;

  // Strobe is combinational from the prescaler so it lines up with the cycle
  // in which the position registers load their next value.
  assign pix_stb  = enable_i & (pre_q == PreMax);
  assign x_at_end = (x_q == XMax);
  assign y_at_end = (y_q == YMax);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pre_d   = pre_q;
    x_d     = x_q;
    y_d     = y_q;
    frame_d = frame_q;

    if (enable_i) begin
      pre_d = (pre_q == PreMax) ? '0 : pre_q + PreW'(1);
    end

    if (pix_stb) begin
      if (x_at_end) begin
        x_d = '0;
        if (y_at_end) begin
          y_d     = '0;
          frame_d = frame_q + FRAME_W'(1);
        end else begin
          y_d = y_q + CNT_W'(1);
        end
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end
  end

  // Reset wins over enable and discards any in-progress wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
    end else begin
      pre_q   <= pre_d;
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Zero-latency decodes from the current position
  // ---------------------------------------------------------------------------
  logic h_sync_act;
  logic v_sync_act;
  logic line_start;

  assign h_sync_act = (x_q >= XSyncStartC) && (x_q < XSyncEndC);
  assign v_sync_act = (y_q >= YSyncStartC) && (y_q < YSyncEndC);
  assign line_start = pix_stb & (x_q == '0);

  assign pix_stb_o     = pix_stb;
  assign hsync_o       = h_sync_act ? HPol : ~HPol;
  assign vsync_o       = v_sync_act ? VPol : ~VPol;
  assign visible_o     = (x_q < XVisEnd) && (y_q < YVisEnd);
  assign line_start_o  = line_start;
  assign frame_start_o = line_start & (y_q == '0);
  assign position_x_o  = x_q;
  assign position_y_o  = y_q;
  assign frame_count_o = frame_q;

endmodule

// File: tb/tb_vga_timer_param.sv
// Bench for vga_timer_param. Three instances share one clock:
//   a: default 640x480 mode, PIX_DIV = 1
//   b: default mode, PIX_DIV = 4
//   c: tiny mode H 8/2/2/2, V 4/1/1/1, active-high syncs (H_TOTAL 14, V_TOTAL 7)
// Inputs change on the falling edge; outputs are sampled 1 ns later.

module tb_vga_timer_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------------------------------------------------------- DUT a
  logic       rst_a, en_a;
  logic       pix_a, hs_a, vs_a, vis_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic [7:0] fc_a;

  vga_timer_param dut_a (
    .clk_i         (clk),
    .rst_i         (rst_a),
    .enable_i      (en_a),
    .pix_stb_o     (pix_a),
    .hsync_o       (hs_a),
    .vsync_o       (vs_a),
    .visible_o     (vis_a),
    .line_start_o  (ls_a),
    .frame_start_o (fs_a),
    .position_x_o  (x_a),
    .position_y_o  (y_a),
    .frame_count_o (fc_a)
  );

  // ---------------------------------------------------------------- DUT b
  logic       rst_b, en_b;
  logic       pix_b, hs_b, vs_b, vis_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;
  logic [7:0] fc_b;

  vga_timer_param #(.PIX_DIV(4)) dut_b (
    .clk_i         (clk),
    .rst_i         (rst_b),
    .enable_i      (en_b),
    .pix_stb_o     (pix_b),
    .hsync_o       (hs_b),
    .vsync_o       (vs_b),
    .visible_o     (vis_b),
    .line_start_o  (ls_b),
    .frame_start_o (fs_b),
    .position_x_o  (x_b),
    .position_y_o  (y_b),
    .frame_count_o (fc_b)
  );

  // ---------------------------------------------------------------- DUT c
  logic       rst_c, en_c;
  logic       pix_c, hs_c, vs_c, vis_c, ls_c, fs_c;
  logic [3:0] x_c, y_c;
  logic [7:0] fc_c;

  vga_timer_param #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .H_SYNC_POL(1), .V_SYNC_POL(1), .PIX_DIV(1), .CNT_W(4), .FRAME_W(8)
  ) dut_c (
    .clk_i         (clk),
    .rst_i         (rst_c),
    .enable_i      (en_c),
    .pix_stb_o     (pix_c),
    .hsync_o       (hs_c),
    .vsync_o       (vs_c),
    .visible_o     (vis_c),
    .line_start_o  (ls_c),
    .frame_start_o (fs_c),
    .position_x_o  (x_c),
    .position_y_o  (y_c),
    .frame_count_o (fc_c)
  );

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst, en;
    int   x, y;
    logic hs, vs, vis, pix, ls, fs;
    int   fc;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rst, input logic en, input int x, input int y,
                         input logic hs, input logic vs, input logic vis, input logic pix,
                         input logic ls, input logic fs, input int fc);
    vec_t v;
    v.rst = rst; v.en = en; v.x = x; v.y = y;
    v.hs = hs; v.vs = vs; v.vis = vis; v.pix = pix; v.ls = ls; v.fs = fs; v.fc = fc;
    vecs.push_back(v);
  endtask

  int mx, my, mfc, nfs;

  initial begin
    rst_a = 1'b1; en_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    rst_c = 1'b1; en_c = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    #1;

    // Reset values, default mode, enable low: syncs idle high (active-low).
    chk("rst_x",   x_a,   0);
    chk("rst_y",   y_a,   0);
    chk("rst_vis", vis_a, 1);
    chk("rst_hs",  hs_a,  1);
    chk("rst_vs",  vs_a,  1);
    chk("rst_pix", pix_a, 0);
    chk("rst_ls",  ls_a,  0);
    chk("rst_fs",  fs_a,  0);
    chk("rst_fc",  fc_a,  0);
    @(negedge clk);

    // ------------------------------------------------ table: tiny mode line
    //       rst en  x  y  hs vs vis pix ls fs fc
    add_vec(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);  // idle after reset
    add_vec(0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0);  // first strobe is frame start
    add_vec(0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    add_vec(0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0);  // pause
    add_vec(0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0);
    add_vec(0, 1, 2, 0, 0, 0, 1, 1, 0, 0, 0);  // resume, no skipped pixel
    for (int x = 3; x <= 13; x++) begin
      add_vec(0, 1, x, 0, (x >= 10 && x < 12), 0, (x < 8), 1, 0, 0, 0);
    end
    add_vec(0, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0);  // x wrapped, y advanced
    add_vec(1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0);  // reset mid-line
    add_vec(0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0);  // restart at frame start

    for (int i = 0; i < vecs.size(); i++) begin
      logic [21:0] act, exp;
      rst_c = vecs[i].rst;
      en_c  = vecs[i].en;
      #1;
      act = {x_c, y_c, hs_c, vs_c, vis_c, pix_c, ls_c, fs_c, fc_c};
      exp = {4'(vecs[i].x), 4'(vecs[i].y), vecs[i].hs, vecs[i].vs, vecs[i].vis,
             vecs[i].pix, vecs[i].ls, vecs[i].fs, 8'(vecs[i].fc)};
      chk($sformatf("vec%0d", i), 32'(act), 32'(exp));
      @(negedge clk);
    end

    // ------------------------------------------------ tiny mode: 5 frames
    rst_c = 1'b1; en_c = 1'b0;
    @(negedge clk);
    rst_c = 1'b0; en_c = 1'b1;
    mx = 0; my = 0; mfc = 0; nfs = 0;
    for (int c = 0; c < 5 * 98; c++) begin
      #1;
      chk("c_x",  x_c,  mx);
      chk("c_y",  y_c,  my);
      chk("c_hs", hs_c, (mx >= 10 && mx < 12));
      chk("c_vs", vs_c, (my == 5));
      chk("c_fs", fs_c, (mx == 0 && my == 0));
      chk("c_fc", fc_c, mfc);
      if (fs_c) nfs++;
      if (mx == 13) begin
        mx = 0;
        if (my == 6) begin
          my = 0;
          mfc++;
        end else begin
          my++;
        end
      end else begin
        mx++;
      end
      @(negedge clk);
    end
    #1;
    chk("c_nfs",   nfs,  5);
    chk("c_fc5",   fc_c, 5);
    chk("c_wrapx", x_c,  0);
    chk("c_wrapy", y_c,  0);
    repeat (3 * 14 + 5) @(negedge clk);
    #1;
    chk("c_mid_x", x_c, 5);
    chk("c_mid_y", y_c, 3);
    rst_c = 1'b1;  // enable stays high: reset must still win
    @(negedge clk);
    rst_c = 1'b0;
    #1;
    chk("c_rst_x",  x_c,  0);
    chk("c_rst_y",  y_c,  0);
    chk("c_rst_fc", fc_c, 0);
    chk("c_rst_hs", hs_c, 0);
    chk("c_rst_vs", vs_c, 0);
    chk("c_rst_fs", fs_c, 1);
    chk("c_rst_ls", ls_c, 1);
    en_c = 1'b0;
    @(negedge clk);

    // ------------------------------------------------ default mode: one line
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0; en_a = 1'b1;
    for (int i = 0; i < 800; i++) begin
      #1;
      chk("a_x",   x_a,   i);
      chk("a_y",   y_a,   0);
      chk("a_hs",  hs_a,  !(i >= 656 && i < 752));
      chk("a_vis", vis_a, (i < 640));
      chk("a_ls",  ls_a,  (i == 0));
      chk("a_fs",  fs_a,  (i == 0));
      @(negedge clk);
    end
    #1;
    chk("a_wrap_x",  x_a,  0);
    chk("a_wrap_y",  y_a,  1);
    chk("a_wrap_ls", ls_a, 1);
    chk("a_wrap_fs", fs_a, 0);
    repeat (300) @(negedge clk);
    #1;
    chk("a_hold_start", x_a, 300);

    // Pause at x = 300 for 50 cycles.
    en_a = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      chk("a_hold_x",   x_a,   300);
      chk("a_hold_pix", pix_a, 0);
      chk("a_hold_ls",  ls_a,  0);
      @(negedge clk);
    end
    en_a = 1'b1;
    #1;
    chk("a_resume_pix", pix_a, 1);
    chk("a_resume_x0",  x_a,   300);
    @(negedge clk);
    #1;
    chk("a_resume_x1", x_a, 301);
    repeat (399) @(negedge clk);
    #1;
    chk("a_pre_rst_x", x_a, 700);
    chk("a_pre_rst_y", y_a, 1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0; en_a = 1'b0;
    #1;
    chk("a_rst2_x",   x_a,   0);
    chk("a_rst2_y",   y_a,   0);
    chk("a_rst2_fc",  fc_a,  0);
    chk("a_rst2_vis", vis_a, 1);
    chk("a_rst2_hs",  hs_a,  1);
    chk("a_rst2_vs",  vs_a,  1);
    chk("a_rst2_pix", pix_a, 0);
    en_a = 1'b1;
    #1;
    chk("a_rst2_fs", fs_a, 1);
    @(negedge clk);
    en_a = 1'b0;

    // ------------------------------------------------ PIX_DIV = 4
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0; en_b = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      chk("b_pix", pix_b, (c % 4 == 3));
      chk("b_x",   x_b,   c / 4);
      chk("b_ls",  ls_b,  (c == 3));
      @(negedge clk);
    end
    en_b = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
